beam_weight_ctrl: RTL and testbench

BEAM_WEIGHT_CTRL -- requirements
Module: beam_weight_ctrl

---
 rtl/beam_weight_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_beam_weight_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/beam_weight_ctrl.sv
// Double-buffered phase-shifter weight controller: writes land in a shadow set,
// which is armed by commit and copied to the active outputs on the next sample_tick.
// Optional beam-2 sweep rotation is compiled in with BEAM_SWEEP_EN.
module beam_weight_ctrl #(
    parameter int unsigned SWEEP_DIV = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic       commit,
    input  logic       sweep_on,
    output logic [4:0] w_cos_1,
    output logic [4:0] w_sin_1,
    output logic [4:0] w_cos_2,
    output logic [4:0] w_sin_2,
    output logic       pending,
    output logic       applied
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    localparam logic [4:0] COS_RST = 5'h0F;
    localparam logic [4:0] SIN_RST = 5'h00;

    state_t     state_q;
    logic       wr_ready_q;
    logic       pending_q;
    logic       applied_q;
    logic [4:0] shadow_q [0:3];
    logic [4:0] shadow_d [0:3];
    logic [4:0] active_q [0:3];
    logic [4:0] active_d [0:3];
    logic       wr_accept_s;
    logic       apply_s;

    assign wr_accept_s = wr_valid & wr_ready_q;
    assign apply_s     = (state_q == ST_ARMED) & sample_tick;

`ifdef BEAM_SWEEP_EN
    localparam logic [15:0] SWEEP_LAST = 16'(SWEEP_DIV - 1);

    logic [15:0] sweep_cnt_q;
    logic [15:0] sweep_cnt_d;
    logic        rotate_s;

    // Negation clamped to the 5-bit range: -(-16) becomes +15.
    function automatic logic [4:0] neg_sat(input logic [4:0] x);
        if (x == 5'h10) begin
            return 5'h0F;
        end else begin
            return 5'(~x + 5'd1);
        end
    endfunction

    // Sweep tick counter; it only runs while idle or loading and restarts on apply.
    always_comb begin
        rotate_s    = 1'b0;
        sweep_cnt_d = sweep_cnt_q;
        if (!sweep_on || apply_s) begin
            sweep_cnt_d = 16'd0;
        end else if (sample_tick && (state_q != ST_ARMED)) begin
            if (sweep_cnt_q == SWEEP_LAST) begin
                sweep_cnt_d = 16'd0;
                rotate_s    = 1'b1;
            end else begin
                sweep_cnt_d = sweep_cnt_q + 16'd1;
            end
        end else begin
            sweep_cnt_d = sweep_cnt_q;
        end
    end

    // Sweep counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            sweep_cnt_q <= 16'd0;
        end else begin
            sweep_cnt_q <= sweep_cnt_d;
        end
    end
`else
    logic [16:0] unused_cfg_s;
    assign unused_cfg_s = {sweep_on, 16'(SWEEP_DIV)};
`endif

    // Next shadow/active contents; application takes priority over a sweep rotation.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (wr_accept_s) begin
            shadow_d[wr_addr] = wr_data;
        end else begin
            shadow_d = shadow_q;
        end
        if (apply_s) begin
            active_d = shadow_q;
`ifdef BEAM_SWEEP_EN
        end else if (rotate_s) begin
            active_d[2] = active_q[3];
            active_d[3] = neg_sat(active_q[2]);
`endif
        end else begin
            active_d = active_q;
        end
    end

    // Weight register files.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q[0] <= COS_RST;
            shadow_q[1] <= SIN_RST;
            shadow_q[2] <= COS_RST;
            shadow_q[3] <= SIN_RST;
            active_q[0] <= COS_RST;
            active_q[1] <= SIN_RST;
            active_q[2] <= COS_RST;
            active_q[3] <= SIN_RST;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ready_q <= 1'b1;
            pending_q  <= 1'b0;
            applied_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    applied_q <= 1'b0;
                    if (wr_accept_s) begin
                        state_q    <= ST_LOAD;
                        wr_ready_q <= 1'b1;
                        pending_q  <= 1'b1;
                    end else begin
                        state_q    <= ST_IDLE;
                        wr_ready_q <= 1'b1;
                        pending_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    applied_q <= 1'b0;
                    pending_q <= 1'b1;
                    if (commit) begin
                        state_q    <= ST_ARMED;
                        wr_ready_q <= 1'b0;
                    end else begin
                        state_q    <= ST_LOAD;
                        wr_ready_q <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (sample_tick) begin
                        state_q    <= ST_IDLE;
                        wr_ready_q <= 1'b1;
                        pending_q  <= 1'b0;
                        applied_q  <= 1'b1;
                    end else begin
                        state_q    <= ST_ARMED;
                        wr_ready_q <= 1'b0;
                        pending_q  <= 1'b1;
                        applied_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    wr_ready_q <= 1'b1;
                    pending_q  <= 1'b0;
                    applied_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready = wr_ready_q;
    assign pending  = pending_q;
    assign applied  = applied_q;
    assign w_cos_1  = active_q[0];
    assign w_sin_1  = active_q[1];
    assign w_cos_2  = active_q[2];
    assign w_sin_2  = active_q[3];

endmodule

// File: tb/tb_beam_weight_ctrl.sv
// Bench for beam_weight_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_beam_weight_ctrl;

    localparam int DIV = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sample_tick = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [1:0] wr_addr = 2'd0;
    logic [4:0] wr_data = 5'd0;
    logic       commit = 1'b0;
    logic       sweep_on = 1'b0;
    logic [4:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;
    logic       pending, applied;

    int vectors = 0;
    int miscompares = 0;

    // reference model: weight sets plus two flags (writes held, set armed)
    int  m_sh  [4];
    int  m_act [4];
    bit  m_loaded, m_armed, m_applied;
    int  m_cnt;

    beam_weight_ctrl #(.SWEEP_DIV(DIV)) dut (
        .clock(clock), .reset(reset), .sample_tick(sample_tick),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .sweep_on(sweep_on),
        .w_cos_1(w_cos_1), .w_sin_1(w_sin_1), .w_cos_2(w_cos_2),
        .w_sin_2(w_sin_2), .pending(pending), .applied(applied)
    );

    always #5 clock = ~clock;

    function automatic int s5(input logic [4:0] x);
        return int'($signed(x));
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sh  = '{15, 0, 15, 0};
        m_act = '{15, 0, 15, 0};
        m_loaded  = 1'b0;
        m_armed   = 1'b0;
        m_applied = 1'b0;
        m_cnt     = 0;
    endtask

    task automatic model_update();
        bit acc, apply, was_armed;
        int tmp;
        if (reset) begin
            model_reset();
        end else begin
            was_armed = m_armed;
            acc   = wr_valid && !m_armed;
            apply = m_armed && sample_tick;
            m_applied = apply;
            if (apply) begin
                m_act    = m_sh;
                m_armed  = 1'b0;
                m_loaded = 1'b0;
            end else if (!m_armed) begin
                if (m_loaded && commit) m_armed = 1'b1;
                if (acc) m_loaded = 1'b1;
            end
            if (acc) m_sh[wr_addr] = s5(wr_data);
`ifdef BEAM_SWEEP_EN
            if (!sweep_on || apply) begin
                m_cnt = 0;
            end else if (sample_tick && !was_armed) begin
                m_cnt++;
                if (m_cnt == DIV) begin
                    m_cnt = 0;
                    tmp = m_act[2];
                    m_act[2] = m_act[3];
                    m_act[3] = (-tmp > 15) ? 15 : -tmp;
                end
            end
`else
            tmp = was_armed;
`endif
        end
    endtask

    // one clock: advance model with the inputs seen at the edge, then compare
    task automatic cycle();
        @(posedge clock);
        model_update();
        #1;
        check("w_cos_1", s5(w_cos_1), m_act[0]);
        check("w_sin_1", s5(w_sin_1), m_act[1]);
        check("w_cos_2", s5(w_cos_2), m_act[2]);
        check("w_sin_2", s5(w_sin_2), m_act[3]);
        check("pending", int'(pending), int'(m_armed || m_loaded));
        check("wr_ready", int'(wr_ready), int'(!m_armed));
        check("applied", int'(applied), int'(m_applied));
    endtask

    task automatic idle_inputs();
        sample_tick = 1'b0; wr_valid = 1'b0; commit = 1'b0; reset = 1'b0;
    endtask

    task automatic write(input logic [1:0] a, input logic [4:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        cycle();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1; cycle(); commit = 1'b0;
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1; cycle(); sample_tick = 1'b0;
    endtask

    initial begin
        model_reset();
        // reset values
        reset = 1'b1; cycle(); cycle();
        idle_inputs(); cycle();
        check("rst_cos1", s5(w_cos_1), 15);
        check("rst_sin1", s5(w_sin_1), 0);
        check("rst_cos2", s5(w_cos_2), 15);
        check("rst_sin2", s5(w_sin_2), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_ready", int'(wr_ready), 1);

        // basic write, commit, tick three cycles later
        write(2'd0, 5'h18);
        write(2'd1, 5'd7);
        pulse_commit();
        check("armed_ready", int'(wr_ready), 0);
        cycle(); cycle();
        check("pre_tick_cos1", s5(w_cos_1), 15);
        pulse_tick();
        check("basic_cos1", s5(w_cos_1), -8);
        check("basic_sin1", s5(w_sin_1), 7);
        check("basic_applied", int'(applied), 1);
        check("basic_cos2", s5(w_cos_2), 15);
        check("basic_sin2", s5(w_sin_2), 0);
        cycle();
        check("applied_once", int'(applied), 0);

        // write + commit + tick in one cycle does not apply on that tick
        write(2'd2, 5'd5);
        wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 5'h1D; commit = 1'b1; sample_tick = 1'b1;
        cycle();
        idle_inputs();
        check("coincident_cos2", s5(w_cos_2), 15);
        check("coincident_pending", int'(pending), 1);
        cycle();
        check("coincident_applied", int'(applied), 0);
        write(2'd2, 5'd9);
        check("armed_refuse_ready", int'(wr_ready), 0);
        pulse_tick();
        check("late_cos2", s5(w_cos_2), 5);
        check("late_sin2", s5(w_sin_2), -3);
        write(2'd3, 5'd1);
        pulse_commit();
        pulse_tick();
        check("partial_cos2", s5(w_cos_2), 5);
        check("partial_sin2", s5(w_sin_2), 1);

        // reset while armed discards the pending set
        write(2'd0, 5'd3);
        pulse_commit();
        reset = 1'b1; cycle(); reset = 1'b0;
        pulse_tick();
        check("rstarm_cos1", s5(w_cos_1), 15);
        check("rstarm_sin2", s5(w_sin_2), 0);
        check("rstarm_applied", int'(applied), 0);

        // beam 2 at (3,-16), then sweep
        write(2'd2, 5'd3);
        write(2'd3, 5'h10);
        pulse_commit();
        pulse_tick();
        sweep_on = 1'b1; cycle();
`ifdef BEAM_SWEEP_EN
        for (int i = 0; i < 4; i++) begin pulse_tick(); cycle(); end
        check("sweep4_cos2", s5(w_cos_2), -16);
        check("sweep4_sin2", s5(w_sin_2), -3);
        for (int i = 0; i < 4; i++) begin pulse_tick(); cycle(); end
        check("sweep8_cos2", s5(w_cos_2), -3);
        check("sweep8_sin2", s5(w_sin_2), 15);
`else
        for (int i = 0; i < 100; i++) begin pulse_tick(); end
        check("nosweep_cos2", s5(w_cos_2), 3);
        check("nosweep_sin2", s5(w_sin_2), -16);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(99) == 0);
            wr_valid    = ($urandom_range(1) == 1);
            wr_addr     = 2'($urandom_range(3));
            wr_data     = 5'($urandom_range(31));
            commit      = ($urandom_range(3) == 0);
            sample_tick = ($urandom_range(4) == 0);
            sweep_on    = ($urandom_range(7) != 0);
            cycle();
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
